multicycle_controller: RTL and testbench



---
 rtl/rv32_ctrl_pkg.sv | 48 ++++
 rtl/alu_decoder.sv | 34 +++
 rtl/multicycle_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM and its ALU decoder.
package rv32_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
  } alu_ctrl_e;

  // Coarse ALU request from the FSM; FUNCT defers to funct3/funct7b5.
  typedef enum logic [1:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_PASSB
  } alu_op_e;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic lt, input logic ltu);
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder: FSM ALU request plus instruction fields to ALUControl.
module alu_decoder
  import rv32_ctrl_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output alu_ctrl_e  alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    unique case (alu_op_i)
      ALUOP_ADD:   alu_ctrl_o = ALU_ADD;
      ALUOP_SUB:   alu_ctrl_o = ALU_SUB;
      ALUOP_PASSB: alu_ctrl_o = ALU_PASSB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // op5 separates R-type sub from addi, whose imm may have bit 30 set
          3'b000: alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl_o = ALU_SLL;
          3'b010: alu_ctrl_o = ALU_SLT;
          3'b011: alu_ctrl_o = ALU_SLTU;
          3'b100: alu_ctrl_o = ALU_XOR;
          3'b101: alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl_o = ALU_OR;
          3'b111: alu_ctrl_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core with MemReady wait, memory timeout trap and branch resolution.
// Define ILLEGAL_INSN_TRAP_EN to trap on unknown opcodes and drive the sticky Illegal flag.
module multicycle_controller
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned ALUCTRL_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Lt,
  input  logic                 Ltu,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 RegWrite,
  output logic                 BusErr,
  output logic                 Illegal
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             buserr_q, buserr_d;
  logic             mem_wait;
  logic             pc_write, ir_write, mem_write, reg_write;
  alu_op_e          alu_op;
  alu_ctrl_e        alu_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      wait_q   <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      buserr_q <= buserr_d;
    end
  end

`ifdef ILLEGAL_INSN_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    buserr_d  = buserr_q;
`ifdef ILLEGAL_INSN_TRAP_EN
    illegal_d = illegal_q;
`endif
    mem_wait  = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = IMM_I;
    alu_op    = ALUOP_ADD;

    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = MemReady;
        pc_write  = MemReady;
        mem_wait  = 1'b1;
        if (MemReady) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_BRANCH: begin
            state_d = BRANCH;
            ImmSrc  = IMM_B;
          end
          OP_JAL: begin
            state_d = JAL;
            ImmSrc  = IMM_J;
          end
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
          default: begin
`ifdef ILLEGAL_INSN_TRAP_EN
            state_d   = TRAP;
            illegal_d = 1'b1;
`else
            state_d   = FETCH;
`endif
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc   = 1'b1;
        mem_wait = 1'b1;
        if (MemReady) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        mem_wait  = 1'b1;
        if (MemReady) state_d = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        ALUSrcA  = 2'b10;
        ImmSrc   = IMM_B;
        alu_op   = ALUOP_SUB;
        pc_write = branch_taken(funct3, Zero, Lt, Ltu);
        state_d  = FETCH;
      end
      JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link OldPC+4
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        ImmSrc   = IMM_J;
        pc_write = 1'b1;
        state_d  = ALUWB;
      end
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      LUI: begin
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_U;
        alu_op  = ALUOP_PASSB;
        state_d = ALUWB;
      end
      AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_U;
        state_d = ALUWB;
      end
      default: state_d = TRAP;
    endcase

    // A ready on the limit cycle completes the access instead of trapping
    if (mem_wait && !MemReady) begin
      if (wait_q == WAIT_LIMIT) begin
        state_d  = TRAP;
        buserr_d = 1'b1;
      end else begin
        wait_d = wait_q + CNT_W'(1);
      end
    end else if (state_d != state_q) begin
      wait_d = '0;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .op5_i      (op[5]),
    .alu_ctrl_o (alu_ctrl)
  );

  assign ALUControl = ALUCTRL_W'(alu_ctrl);
  assign PCWrite    = pc_write  & ~reset;
  assign IRWrite    = ir_write  & ~reset;
  assign MemWrite   = mem_write & ~reset;
  assign RegWrite   = reg_write & ~reset;
  assign BusErr     = buserr_q;

`ifdef ILLEGAL_INSN_TRAP_EN
  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction sequencing, memory waits, timeout and reset abort.
module tb_multicycle_controller;
  import rv32_ctrl_pkg::*;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, Lt, Ltu, MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, BusErr, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  int n_cmp = 0;
  int n_bad = 0;
  int acc;

  multicycle_controller #(.MEM_TIMEOUT(15), .ALUCTRL_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .Lt         (Lt),
    .Ltu        (Ltu),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .BusErr     (BusErr),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next cycle, drive MemReady for it, sample mid-cycle.
  task automatic step(input logic mr);
    @(negedge clk);
    MemReady = mr;
    #1;
  endtask

  // Pulse reset for one cycle; returns inside the first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_buserr", 32'(BusErr), 0);
    check("rst_illegal", 32'(Illegal), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b1; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
    Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;

    #19;
    check("reset_pcwrite", 32'(PCWrite), 0);
    check("reset_irwrite", 32'(IRWrite), 0);
    check("reset_regwrite", 32'(RegWrite), 0);
    check("reset_memwrite", 32'(MemWrite), 0);
    check("reset_buserr", 32'(BusErr), 0);
    check("reset_illegal", 32'(Illegal), 0);
    #3 reset = 1'b0;
    #1;

    // R-type add: FETCH, DECODE, EXECR, ALUWB
    check("r_c1_pcwrite", 32'(PCWrite), 1);
    check("r_c1_irwrite", 32'(IRWrite), 1);
    check("r_c1_srcb", 32'(ALUSrcB), 2);
    check("r_c1_result", 32'(ResultSrc), 2);
    check("r_c1_regwrite", 32'(RegWrite), 0);
    step(1);
    check("r_c2_pcwrite", 32'(PCWrite), 0);
    check("r_c2_srca", 32'(ALUSrcA), 1);
    check("r_c2_srcb", 32'(ALUSrcB), 1);
    check("r_c2_regwrite", 32'(RegWrite), 0);
    step(1);
    check("r_c3_srca", 32'(ALUSrcA), 2);
    check("r_c3_srcb", 32'(ALUSrcB), 0);
    check("r_c3_alu", 32'(ALUControl), 32'(ALU_ADD));
    check("r_c3_regwrite", 32'(RegWrite), 0);
    step(1);
    check("r_c4_regwrite", 32'(RegWrite), 1);
    check("r_c4_result", 32'(ResultSrc), 0);
    check("r_c4_pcwrite", 32'(PCWrite), 0);

    // lw with two MemReady-low cycles in MEMREAD
    op = OP_LOAD;
    step(1);
    check("lw_c1_irwrite", 32'(IRWrite), 1);
    acc = 0;
    for (int c = 2; c <= 7; c++) begin
      step((c == 4 || c == 5) ? 1'b0 : 1'b1);
      acc += int'(AdrSrc);
      if (c == 6) check("lw_c6_regwrite", 32'(RegWrite), 0);
    end
    check("lw_c7_regwrite", 32'(RegWrite), 1);
    check("lw_c7_result", 32'(ResultSrc), 1);
    check("lw_adrsrc_cycles", 32'(acc), 3);

    // beq taken, then bge not taken
    op = OP_BRANCH; funct3 = 3'b000; Zero = 1'b1;
    step(1);
    check("beq_c1_irwrite", 32'(IRWrite), 1);
    step(1);
    check("beq_c2_imm", 32'(ImmSrc), 2);
    step(1);
    check("beq_c3_pcwrite", 32'(PCWrite), 1);
    check("beq_c3_alu", 32'(ALUControl), 32'(ALU_SUB));
    check("beq_c3_srca", 32'(ALUSrcA), 2);
    funct3 = 3'b101; Lt = 1'b1; Zero = 1'b0;
    step(1);
    check("bge_c1_irwrite", 32'(IRWrite), 1);
    step(1);
    step(1);
    check("bge_c3_pcwrite", 32'(PCWrite), 0);

    // jal
    op = OP_JAL;
    step(1);
    step(1);
    check("jal_c2_imm", 32'(ImmSrc), 3);
    step(1);
    check("jal_c3_pcwrite", 32'(PCWrite), 1);
    check("jal_c3_srca", 32'(ALUSrcA), 1);
    check("jal_c3_srcb", 32'(ALUSrcB), 2);
    step(1);
    check("jal_c4_regwrite", 32'(RegWrite), 1);

    // srai
    op = OP_I; funct3 = 3'b101; funct7b5 = 1'b1;
    step(1);
    step(1);
    step(1);
    check("srai_alu", 32'(ALUControl), 32'(ALU_SRA));
    check("srai_srcb", 32'(ALUSrcB), 1);
    step(1);
    check("srai_regwrite", 32'(RegWrite), 1);

    // lui
    op = OP_LUI; funct3 = 3'b000; funct7b5 = 1'b0;
    step(1);
    step(1);
    step(1);
    check("lui_alu", 32'(ALUControl), 32'(ALU_PASSB));
    check("lui_imm", 32'(ImmSrc), 4);
    step(1);
    check("lui_regwrite", 32'(RegWrite), 1);

    // sw with MemReady stuck low: timeout trap
    op = OP_STORE;
    step(1);
    step(1);
    step(1);
    check("sw_memadr_imm", 32'(ImmSrc), 1);
    acc = 0;
    for (int c = 0; c < 25; c++) begin
      step(1'b0);
      acc += int'(MemWrite);
    end
    check("sw_to_memwrite_cycles", 32'(acc), 15);
    check("sw_to_buserr", 32'(BusErr), 1);
    step(1);
    check("trap_irwrite", 32'(IRWrite), 0);
    check("trap_pcwrite", 32'(PCWrite), 0);
    check("trap_buserr_sticky", 32'(BusErr), 1);
    do_reset();
    check("post_rst_irwrite", 32'(IRWrite), 1);

    // sw with MemReady arriving on the limit cycle
    step(1);
    step(1);
    acc = 0;
    for (int c = 1; c <= 15; c++) begin
      step(c == 15);
      acc += int'(MemWrite);
    end
    check("sw_lim_memwrite_cycles", 32'(acc), 15);
    step(1);
    check("sw_lim_fetch_irwrite", 32'(IRWrite), 1);
    check("sw_lim_buserr", 32'(BusErr), 0);

    // Unknown opcode
    op = 7'b0000000;
    step(1);
    check("ill_dec_regwrite", 32'(RegWrite), 0);
    check("ill_dec_memwrite", 32'(MemWrite), 0);
    check("ill_dec_pcwrite", 32'(PCWrite), 0);
    step(1);
`ifdef ILLEGAL_INSN_TRAP_EN
    check("ill_flag", 32'(Illegal), 1);
    check("ill_trap_irwrite", 32'(IRWrite), 0);
`else
    check("ill_flag", 32'(Illegal), 0);
    check("ill_nop_irwrite", 32'(IRWrite), 1);
`endif
    check("ill_regwrite", 32'(RegWrite), 0);
    op = OP_STORE;
    do_reset();

    // Reset asserted mid-MEMWRITE
    step(1);
    step(1);
    step(1'b0);
    check("abort_memwrite_c1", 32'(MemWrite), 1);
    step(1'b0);
    check("abort_memwrite_c2", 32'(MemWrite), 1);
    #2 reset = 1'b1;
    #1;
    check("abort_memwrite_drop", 32'(MemWrite), 0);
    check("abort_adrsrc", 32'(AdrSrc), 0);
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b1;
    #1;
    check("abort_fetch_irwrite", 32'(IRWrite), 1);
    check("abort_fetch_adrsrc", 32'(AdrSrc), 0);
    step(1);
    check("abort_decode_srca", 32'(ALUSrcA), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
